// File: rtl/uart_rx16_fifo.sv
// uart_rx16_fifo: 8N1 UART receiver with 16x oversampling, 3-sample majority
// vote per bit, false-start rejection, stop-bit framing check and a
// DEPTH-entry first-word-fall-through receive FIFO with sticky error flags.
module uart_rx16_fifo #(
    parameter int CLKFREQ = 50000000,
    parameter int BAUD    = 115200,
    parameter int DEPTH   = 16
) (
    input  logic                       clk,
    input  logic                       resetq,
    input  logic                       uart_rx,
    input  logic                       rd,
    output logic                       valid,
    output logic [7:0]                 data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ferr,
    output logic                       overrun,
    input  logic                       clr_err
);

    localparam int DIV = CLKFREQ / (16 * BAUD);
    localparam int DVW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state;
    logic           rx1, rxs, rxp;
    logic [DVW-1:0] div_cnt;
    logic [3:0]     tcnt;
    logic           s0, s1;
    logic [2:0]     bitn;
    logic [7:0]     shreg;

    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wp, rp;
    logic [CW-1:0]  cnt;

    logic start_edge, tick, decide, maj, stop_dec, push, pop, full, wr;

    assign start_edge = (state == IDLE) && rxp && !rxs;
    assign tick       = (div_cnt == DVW'(DIV - 1));
    assign decide     = tick && (tcnt == 4'd9);
    // The third sample is the live rxs value on the decision tick.
    assign maj        = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
    assign stop_dec   = (state == STOP) && decide;
    assign push       = stop_dec && maj;
    assign pop        = rd && (cnt != '0);
    assign full       = (cnt == CW'(DEPTH));
    assign wr         = push && (!full || pop);

    assign valid   = (cnt != '0);
    assign data    = valid ? mem[rp] : '0;
    assign count   = cnt;

    // Two-flop synchronizer plus previous-sample register for edge detection
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx1 <= 1'b1;
            rxs <= 1'b1;
            rxp <= 1'b1;
        end else begin
            rx1 <= uart_rx;
            rxs <= rx1;
            rxp <= rxs;
        end
    end

    // 16x tick divider and tick counter, realigned to each start edge
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            div_cnt <= '0;
            tcnt    <= '0;
        end else if (start_edge) begin
            div_cnt <= '0;
            tcnt    <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            tcnt    <= tcnt + 4'd1;
        end else begin
            div_cnt <= div_cnt + DVW'(1);
        end
    end

    // Receive FSM: sample collection, bit decisions and byte assembly
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state <= IDLE;
            s0    <= 1'b1;
            s1    <= 1'b1;
            bitn  <= '0;
            shreg <= '0;
        end else begin
            if (tick && tcnt == 4'd7) s0 <= rxs;
            if (tick && tcnt == 4'd8) s1 <= rxs;
            case (state)
                IDLE:  if (start_edge) state <= START;
                START: if (decide) begin
                    bitn  <= '0;
                    state <= maj ? IDLE : DATA;
                end
                DATA:  if (decide) begin
                    shreg <= {maj, shreg[7:1]};
                    bitn  <= bitn + 3'd1;
                    if (bitn == 3'd7) state <= STOP;
                end
                STOP:  if (decide) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers, occupancy and sticky error flags
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            ferr    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (wr)  wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            case ({wr, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (stop_dec && !maj)          ferr <= 1'b1;
            else if (clr_err)              ferr <= 1'b0;
            if (push && full && !pop)      overrun <= 1'b1;
            else if (clr_err)              overrun <= 1'b0;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= shreg;
    end

endmodule

// File: tb/tb_uart_rx16_fifo.sv
// Self-checking bench for uart_rx16_fifo. Runs with a fast clock ratio
// (divider of 4, 64 clk per bit) to keep simulation short.
`timescale 1ns/1ps
module tb_uart_rx16_fifo;

    localparam int CLKFREQ = 7372800;
    localparam int BAUD    = 115200;
    localparam int DEPTH   = 16;
    localparam int DIV     = CLKFREQ / (16 * BAUD);
    localparam int BIT     = 16 * DIV;
    localparam int CW      = $clog2(DEPTH) + 1;
    // Negedges after the start-bit falling edge until the cycle whose rising
    // edge carries the stop-bit decision (2 sync flops + 154 ticks).
    localparam int STOP_DEC = 2 + DIV * 154;

    logic          clk = 1'b0;
    logic          resetq, uart_rx, rd, clr_err;
    logic          valid, ferr, overrun;
    logic [7:0]    data;
    logic [CW-1:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q[$];
    logic       m_ferr, m_over;

    uart_rx16_fifo #(.CLKFREQ(CLKFREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetq(resetq), .uart_rx(uart_rx), .rd(rd),
        .valid(valid), .data(data), .count(count), .ferr(ferr),
        .overrun(overrun), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference: a completed frame either lands in the queue, sets overrun, or sets ferr
    task automatic model_frame(input logic [7:0] b, input bit stop);
        if (!stop) m_ferr = 1'b1;
        else if (q.size() < DEPTH) q.push_back(b);
        else m_over = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop, input int per);
        @(negedge clk) uart_rx = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (per) @(negedge clk);
        end
        uart_rx = stop;
        repeat (per) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic pop_one();
        @(negedge clk) rd = 1'b1;
        @(negedge clk) rd = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk) clr_err = 1'b1;
        @(negedge clk) clr_err = 1'b0;
        m_ferr = 1'b0;
        m_over = 1'b0;
    endtask

    task automatic test_reset();
        resetq = 1'b0; uart_rx = 1'b1; rd = 1'b0; clr_err = 1'b0;
        q.delete(); m_ferr = 1'b0; m_over = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({valid, data, count, ferr, overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got valid=%b data=%h count=%0d ferr=%b ovr=%b exp all 0",
                     valid, data, count, ferr, overrun);
        end
        resetq = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_single();
        send_byte(8'h55, 1'b1, BIT); model_frame(8'h55, 1'b1);
        n_tests++;
        if (valid !== 1'b1 || data !== 8'h55 || count !== CW'(1) || ferr !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rx got valid=%b data=%h count=%0d ferr=%b exp 1 55 1 0",
                     valid, data, count, ferr);
        end
        pop_one(); void'(q.pop_front());
        n_tests++;
        if (valid !== 1'b0 || count !== CW'(0) || data !== 8'h00) begin
            n_fail++;
            $display("FAIL single_pop got valid=%b data=%h count=%0d exp 0 00 0", valid, data, count);
        end
    endtask

    task automatic test_false_start();
        logic [7:0] b;
        @(negedge clk) uart_rx = 1'b0;
        repeat ($urandom_range(1, 25)) @(negedge clk);
        uart_rx = 1'b1;
        repeat (BIT * 2) @(negedge clk);
        n_tests++;
        if (valid !== 1'b0 || ferr !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL false_start got valid=%b ferr=%b ovr=%b exp 0 0 0", valid, ferr, overrun);
        end
        b = 8'h3C;
        send_byte(b, 1'b1, BIT); model_frame(b, 1'b1);
        n_tests++;
        if (valid !== 1'b1 || data !== q[0] || count !== CW'(q.size())) begin
            n_fail++;
            $display("FAIL after_glitch got valid=%b data=%h count=%0d exp 1 %h %0d",
                     valid, data, count, q[0], q.size());
        end
        pop_one(); void'(q.pop_front());
    endtask

    task automatic test_framing();
        logic [7:0] b;
        send_byte(8'hA5, 1'b0, BIT); model_frame(8'hA5, 1'b0);
        n_tests++;
        if (ferr !== m_ferr || count !== CW'(q.size())) begin
            n_fail++;
            $display("FAIL ferr_set got ferr=%b count=%0d exp %b %0d", ferr, count, m_ferr, q.size());
        end
        pulse_clr();
        n_tests++;
        if (ferr !== m_ferr) begin
            n_fail++;
            $display("FAIL ferr_clear got %b exp %b", ferr, m_ferr);
        end
        // clr_err coincident with the failing stop-bit decision: set wins
        b = 8'($urandom);
        fork
            send_byte(b, 1'b0, BIT);
            begin
                @(negedge clk);
                repeat (STOP_DEC) @(negedge clk);
                clr_err = 1'b1;
                @(negedge clk) clr_err = 1'b0;
            end
        join
        model_frame(b, 1'b0);
        n_tests++;
        if (ferr !== m_ferr) begin
            n_fail++;
            $display("FAIL ferr_set_vs_clr got %b exp %b", ferr, m_ferr);
        end
        pulse_clr();
        send_byte(8'h5A, 1'b1, BIT); model_frame(8'h5A, 1'b1);
        n_tests++;
        if (valid !== 1'b1 || data !== 8'h5A || ferr !== 1'b0) begin
            n_fail++;
            $display("FAIL after_ferr got valid=%b data=%h ferr=%b exp 1 5a 0", valid, data, ferr);
        end
        pop_one(); void'(q.pop_front());
    endtask

    task automatic test_overrun();
        logic [7:0] b;
        for (int i = 0; i <= DEPTH; i++) begin
            send_byte(8'(i), 1'b1, BIT); model_frame(8'(i), 1'b1);
        end
        n_tests++;
        if (count !== CW'(q.size()) || overrun !== m_over || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_full got count=%0d ovr=%b exp %0d %b", count, overrun, q.size(), m_over);
        end
        pulse_clr();
        n_tests++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear got %b exp 0", overrun);
        end
        while (q.size() > 0) begin
            n_tests++;
            if (valid !== 1'b1 || data !== q[0] || count !== CW'(q.size())) begin
                n_fail++;
                $display("FAIL overrun_drain got data=%h count=%0d exp %h %0d", data, count, q[0], q.size());
            end
            pop_one(); void'(q.pop_front());
        end
        // Refill, then pop on exactly the push cycle while full
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            send_byte(b, 1'b1, BIT); model_frame(b, 1'b1);
        end
        b = 8'($urandom);
        fork
            send_byte(b, 1'b1, BIT);
            begin
                @(negedge clk);
                repeat (STOP_DEC) @(negedge clk);
                rd = 1'b1;
                @(negedge clk) rd = 1'b0;
            end
        join
        void'(q.pop_front());
        model_frame(b, 1'b1);
        n_tests++;
        if (count !== CW'(DEPTH) || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL push_pop_full got count=%0d ovr=%b exp %0d 0", count, overrun, DEPTH);
        end
        while (q.size() > 0) begin
            n_tests++;
            if (data !== q[0] || count !== CW'(q.size())) begin
                n_fail++;
                $display("FAIL push_pop_drain got data=%h count=%0d exp %h %0d", data, count, q[0], q.size());
            end
            pop_one(); void'(q.pop_front());
        end
    endtask

    task automatic test_back_to_back();
        int pers[2];
        logic [7:0] bytes[3];
        pers[0] = BIT - 2; pers[1] = BIT + 2;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h81;
        foreach (pers[p]) begin
            for (int i = 0; i < 3; i++) begin
                send_byte(bytes[i], 1'b1, pers[p]); model_frame(bytes[i], 1'b1);
            end
            n_tests++;
            if (count !== CW'(q.size()) || ferr !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_per%0d got count=%0d ferr=%b exp %0d 0", pers[p], count, ferr, q.size());
            end
            while (q.size() > 0) begin
                n_tests++;
                if (data !== q[0]) begin
                    n_fail++;
                    $display("FAIL b2b_data_per%0d got %h exp %h", pers[p], data, q[0]);
                end
                pop_one(); void'(q.pop_front());
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit st;
        for (int i = 0; i < 10; i++) begin
            b  = 8'($urandom);
            st = ($urandom_range(0, 4) != 0);
            send_byte(b, st, $urandom_range(BIT - 2, BIT + 2));
            model_frame(b, st);
            if ($urandom_range(0, 2) == 0 && q.size() > 0) begin
                pop_one(); void'(q.pop_front());
            end
            n_tests++;
            if (ferr !== m_ferr || overrun !== m_over || count !== CW'(q.size()) ||
                (q.size() > 0 && data !== q[0])) begin
                n_fail++;
                $display("FAIL random_%0d got ferr=%b ovr=%b count=%0d data=%h exp ferr=%b ovr=%b count=%0d",
                         i, ferr, overrun, count, data, m_ferr, m_over, q.size());
            end
        end
        while (q.size() > 0) begin
            n_tests++;
            if (data !== q[0]) begin
                n_fail++;
                $display("FAIL random_drain got %h exp %h", data, q[0]);
            end
            pop_one(); void'(q.pop_front());
        end
        pulse_clr();
    endtask

    task automatic test_reset_midbyte();
        send_byte(8'h11, 1'b1, BIT); model_frame(8'h11, 1'b1);
        send_byte(8'h22, 1'b0, BIT); model_frame(8'h22, 1'b0);
        fork
            send_byte(8'h96, 1'b1, BIT);
            begin
                @(negedge clk);
                repeat (5 * BIT + BIT / 2) @(negedge clk);
                resetq = 1'b0;
                #1;
                n_tests++;
                if ({valid, data, count, ferr, overrun} !== '0) begin
                    n_fail++;
                    $display("FAIL midbyte_reset got valid=%b data=%h count=%0d ferr=%b ovr=%b exp all 0",
                             valid, data, count, ferr, overrun);
                end
            end
        join
        q.delete(); m_ferr = 1'b0; m_over = 1'b0;
        @(negedge clk) resetq = 1'b1;
        repeat (20) @(negedge clk);
        send_byte(8'h69, 1'b1, BIT); model_frame(8'h69, 1'b1);
        n_tests++;
        if (data !== 8'h69 || count !== CW'(1) || ferr !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset got data=%h count=%0d ferr=%b exp 69 1 0", data, count, ferr);
        end
        pop_one(); void'(q.pop_front());
    endtask

    initial begin
        test_reset();
        test_single();
        test_false_start();
        test_framing();
        test_overrun();
        test_back_to_back();
        test_random();
        test_reset_midbyte();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
